// File: rtl/fifo_read_ctrl_pkg.sv
// Shared definitions for the async FIFO read side.
//   FIFO_WIDTH / FIFO_ADDR_WIDTH / FIFO_DEPTH : default geometry of the FIFO memory
//   buf_op_e  : what the output buffer does in a cycle (capture and/or pop)
//   bin2gray  : binary-to-Gray conversion shared by both pointer blocks
package fifo_read_ctrl_pkg;

    localparam int FIFO_WIDTH      = 8;
    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_DEPTH      = 2 ** FIFO_ADDR_WIDTH;

    // Encoded as {capture, pop} so it can be built directly from the two strobes.
    typedef enum logic [1:0] {
        BUF_IDLE = 2'b00,
        BUF_POP  = 2'b01,
        BUF_PUSH = 2'b10,
        BUF_BOTH = 2'b11
    } buf_op_e;

    // Works at any pointer width up to 32 bits; callers slice the result.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return (b >> 1) ^ b;
    endfunction

endpackage

// File: rtl/fifo_read_ctrl_if.sv
// Valid/ready stream carrying words out of the FIFO read side.
//   dout       : stream data (head of the output buffer)
//   dout_valid : stream valid
//   dout_ready : consumer ready; a word moves when dout_valid & dout_ready
// master = producer (the FIFO), slave = consumer.
interface fifo_read_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order valid/ready buffer with an external capture strobe.
//   clk, rst   : clock and synchronous active-high reset
//   capture    : load cap_data this cycle (caller guarantees the buffer is not full
//                once any same-cycle pop is accounted for)
//   cap_data   : word to load
//   out_ready  : downstream ready
//   out_data   : head entry (always slot 0)
//   out_valid  : buffer holds at least one word
//   count      : number of buffered words (0..2)
module fifo_skid_buf
    import fifo_read_ctrl_pkg::*;
#(
    parameter int DATA_W = FIFO_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [1:0]        count
);

    logic [1:0][DATA_W-1:0] slot_reg;
    logic [1:0][DATA_W-1:0] slot_next;
    logic [1:0]             count_reg;
    logic [1:0]             count_next;
    logic                   pop;
    logic                   wr_pos;
    buf_op_e                op;

    assign out_valid = (count_reg != 2'd0);
    assign out_data  = slot_reg[0];
    assign count     = count_reg;
    assign pop       = out_valid & out_ready;
    assign op        = buf_op_e'({capture, pop});

    // A captured word lands in the first slot that is free after this cycle's pop:
    // slot 1 when one word stays behind, otherwise slot 0.
    assign wr_pos = (count_reg == 2'd2) | ((count_reg == 2'd1) & ~pop);

    // Slot 0 takes the capture or shifts up from slot 1 on a pop; slot 1 only
    // changes on a capture (its stale value is harmless once it is not counted).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign slot_next[gi] = (capture && (wr_pos == 1'(gi))) ? cap_data :
                                   (pop && (gi == 0))              ? slot_reg[1] :
                                                                     slot_reg[gi];
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case (op)
            BUF_POP:  count_next = count_reg - 2'd1;
            BUF_PUSH: count_next = count_reg + 2'd1;
            default:  count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_reg  <= '0;
            count_reg <= 2'd0;
        end else begin
            slot_reg  <= slot_next;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the async FIFO. Owns the read pointer, the empty flag
// and the memory read port, and turns the one-cycle-latency RAM read into a
// valid/ready stream. Single clock domain (r_clk); rq2_wptr arrives already
// synchronised.
//   r_clk, r_rst : read clock, synchronous active-high reset
//   rq2_wptr     : Gray write pointer synchronised into r_clk
//   r_ptr        : registered Gray read pointer, to the write-side synchroniser
//   r_empty      : registered, no unfetched entries in memory
//   r_en, r_addr : memory read port (data returns on r_data_mem one cycle later)
//   r_data_mem   : memory read data
//   strm         : output stream (dout / dout_valid / dout_ready)
module fifo_read_ctrl
    import fifo_read_ctrl_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_WIDTH,
    parameter int DATA_W = FIFO_WIDTH
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic [ADDR_W:0]   rq2_wptr,
    output logic [ADDR_W:0]   r_ptr,
    output logic              r_empty,
    output logic              r_en,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [DATA_W-1:0] r_data_mem,
    fifo_read_ctrl_if.master  strm
);

    logic [ADDR_W:0] rbin_reg;
    logic [ADDR_W:0] rbin_next;
    logic [ADDR_W:0] r_ptr_reg;
    logic [ADDR_W:0] r_ptr_next;
    logic [31:0]     gray_full;
    logic            r_empty_reg;
    logic            inflight_reg;
    logic [1:0]      buf_count;
    logic [1:0]      occ;
    logic            pop;
    logic            fetch;

    // Words committed to the stream but not yet handed over: buffered plus the
    // read currently in flight. Fetching only while occ < 2 (or while a pop
    // frees a place) keeps the buffer from ever overflowing.
    assign occ   = buf_count + {1'b0, inflight_reg};
    assign pop   = strm.dout_valid & strm.dout_ready;
    assign fetch = ~r_rst & ~r_empty_reg & ((occ < 2'd2) | pop);

    assign r_en      = fetch;
    assign r_addr    = rbin_reg[ADDR_W-1:0];
    assign rbin_next = rbin_reg + {{ADDR_W{1'b0}}, fetch};
    assign gray_full = bin2gray(32'(rbin_next));
    assign r_ptr_next = gray_full[ADDR_W:0];

    assign r_ptr   = r_ptr_reg;
    assign r_empty = r_empty_reg;

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            rbin_reg     <= '0;
            r_ptr_reg    <= '0;
            r_empty_reg  <= 1'b1;
            inflight_reg <= 1'b0;
        end else begin
            rbin_reg     <= rbin_next;
            r_ptr_reg    <= r_ptr_next;
            // Compared against the look-ahead pointer so the last fetch raises
            // empty on the very next cycle.
            r_empty_reg  <= (r_ptr_next == rq2_wptr);
            inflight_reg <= fetch;
        end
    end

    // The in-flight flag doubles as the capture strobe: RAM data is valid
    // exactly one cycle after the fetch. Reset clears it, so a read that was
    // in flight across reset is never captured.
    fifo_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid_buf (
        .clk       (r_clk),
        .rst       (r_rst),
        .capture   (inflight_reg),
        .cap_data  (r_data_mem),
        .out_ready (strm.dout_ready),
        .out_data  (strm.dout),
        .out_valid (strm.dout_valid),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: a memory plus a write-side model that counts words
// written, fetched and delivered, and checks the stream against the word queue.
module tb_fifo_read_ctrl;
    import fifo_read_ctrl_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = FIFO_DEPTH;

    logic          r_clk = 1'b0;
    logic          r_rst;
    logic [AW:0]   rq2_wptr;
    logic [AW:0]   r_ptr;
    logic          r_empty;
    logic          r_en;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data_mem;

    fifo_read_ctrl_if #(.DATA_W(DW)) strm ();

    fifo_read_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .r_clk      (r_clk),
        .r_rst      (r_rst),
        .rq2_wptr   (rq2_wptr),
        .r_ptr      (r_ptr),
        .r_empty    (r_empty),
        .r_en       (r_en),
        .r_addr     (r_addr),
        .r_data_mem (r_data_mem),
        .strm       (strm)
    );

    always #5 r_clk = ~r_clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge r_clk) if (r_en) r_data_mem <= mem[r_addr];

    int checks = 0, errors = 0;
    int wcnt, fetch_cnt, xfer_cnt, vis, vis_d1, vis_d2, prev_vis, lag, cyc;
    int first_x, last_x, wr_total, wr_prob;
    bit mon_on, prev_stall;
    logic [DW-1:0] prev_dout, word0;
    logic [DW-1:0] exp_q[$];
    logic          s_en, s_valid, s_empty;
    logic [DW-1:0] s_dout;
    logic [AW-1:0] s_addr;
    logic [AW:0]   s_ptr;

    function automatic logic [AW:0] tb_gray(input int n);
        logic [AW:0] b;
        b = n[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        mem[wcnt % DEPTH] = d;
        exp_q.push_back(d);
        wcnt++;
    endtask

    // One clock cycle: publish the (possibly lagged) write count, sample and
    // check at the negative edge, then step past the rising edge.
    task automatic tick();
        vis_d2 = vis_d1;
        vis_d1 = wcnt;
        vis = (lag > 0) ? vis_d2 : wcnt;
        rq2_wptr = tb_gray(vis);
        @(negedge r_clk);
        s_en = r_en; s_valid = strm.dout_valid; s_dout = strm.dout;
        s_addr = r_addr; s_ptr = r_ptr; s_empty = r_empty;
        if (mon_on) begin
            chk("occ_le_2", 32'(fetch_cnt - xfer_cnt <= 2), 1);
            chk("r_ptr", s_ptr, tb_gray(fetch_cnt));
            chk("r_empty", s_empty, fetch_cnt == prev_vis);
            if (prev_stall) begin
                chk("hold_valid", s_valid, 1);
                chk("hold_dout", s_dout, prev_dout);
            end
            if (s_en) begin
                chk("r_addr", s_addr, fetch_cnt % DEPTH);
                chk("no_overread", 32'(fetch_cnt < prev_vis), 1);
                fetch_cnt++;
            end
            if (s_valid && strm.dout_ready) begin
                if (exp_q.size() == 0) chk("spurious_word", exp_q.size(), 1);
                else chk("dout", s_dout, exp_q.pop_front());
                xfer_cnt++;
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
            end
            prev_stall = s_valid & ~strm.dout_ready;
            prev_dout  = s_dout;
        end
        @(posedge r_clk);
        #1;
        cyc++;
        prev_vis = vis;
    endtask

    task automatic do_reset(input int n, input logic [AW:0] wptr);
        mon_on = 0;
        r_rst = 1'b1;
        rq2_wptr = wptr;
        for (int i = 0; i < n; i++) begin
            @(negedge r_clk);
            chk("rst_r_en", r_en, 0);
            chk("rst_dout_valid", strm.dout_valid, 0);
            @(posedge r_clk);
            #1;
        end
        chk("rst_r_empty", r_empty, 1);
        chk("rst_r_ptr", r_ptr, 0);
        chk("rst_dout", strm.dout, 0);
        r_rst = 1'b0;
        wcnt = 0; fetch_cnt = 0; xfer_cnt = 0;
        vis = 0; vis_d1 = 0; vis_d2 = 0; prev_vis = 0;
        prev_stall = 0;
        exp_q.delete();
        rq2_wptr = '0;
        mon_on = 1;
    endtask

    task automatic prefill();
        while (wcnt < wr_total && wcnt - fetch_cnt < DEPTH) write_word(DW'($urandom));
    endtask

    // mode 1: ready always high, 2: ready toggles 1010..., 3: random ready
    task automatic run(input int mode, input int maxcyc);
        int n;
        n = 0;
        while (xfer_cnt < wr_total && n < maxcyc) begin
            case (mode)
                1:       strm.dout_ready = 1'b1;
                2:       strm.dout_ready = ~n[0];
                default: strm.dout_ready = 1'($urandom_range(1));
            endcase
            if (wcnt < wr_total && wcnt - fetch_cnt < DEPTH && $urandom_range(99) < wr_prob)
                write_word(DW'($urandom));
            tick();
            n++;
        end
        chk("delivered_count", xfer_cnt, wr_total);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        strm.dout_ready = 1'b0;
        lag = 0; cyc = 0; first_x = -1; last_x = -1; wr_prob = 100;
        mon_on = 0; prev_stall = 0;

        // Reset with a non-zero write pointer present
        do_reset(3, 5'b00011);
        $display("reset: r_empty=%0d r_ptr=%0h", r_empty, r_ptr);

        // Single word
        strm.dout_ready = 1'b1;
        write_word(8'hA5);
        tick();
        chk("single_c0_no_ren", s_en, 0);
        tick();
        chk("single_c1_ren", s_en, 1);
        chk("single_c1_addr", s_addr, 0);
        tick();
        chk("single_c2_valid", s_valid, 0);
        tick();
        chk("single_c3_valid", s_valid, 1);
        chk("single_c3_dout", s_dout, 8'hA5);
        chk("single_r_ptr", s_ptr, 5'b00001);
        tick();
        chk("single_count", xfer_cnt, 1);
        $display("single: dout=%0h delivered=%0d", s_dout, xfer_cnt);

        // Backpressure: 4 words queued, consumer stalled
        strm.dout_ready = 1'b0;
        word0 = 8'h3C;
        write_word(word0);
        for (int i = 0; i < 3; i++) write_word(DW'($urandom));
        begin
            int base;
            base = fetch_cnt;
            for (int i = 0; i < 10; i++) tick();
            chk("bp_ren_pulses", fetch_cnt - base, 2);
        end
        chk("bp_valid", s_valid, 1);
        chk("bp_head", s_dout, word0);
        wr_total = wcnt;
        run(1, 50);
        $display("backpressure: delivered=%0d", xfer_cnt);

        // Streaming across the pointer wrap, gapless output
        wr_total = wcnt + 40;
        prefill();
        first_x = -1;
        run(1, 200);
        chk("stream_gapless", last_x - first_x, 39);
        $display("stream: delivered=%0d span=%0d", xfer_cnt, last_x - first_x);

        // Ready toggling 1010...
        wr_total = wcnt + 20;
        prefill();
        run(2, 200);
        $display("toggle: delivered=%0d", xfer_cnt);

        // Random traffic with a lagging write pointer
        lag = 2; wr_prob = 40;
        wr_total = wcnt + 60;
        run(3, 2000);
        lag = 0; wr_prob = 100;
        for (int i = 0; i < 3; i++) tick();
        $display("random: delivered=%0d fetched=%0d", xfer_cnt, fetch_cnt);

        // Reset the cycle after a read is issued
        strm.dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) write_word(DW'($urandom));
        begin
            int n;
            n = 0;
            s_en = 1'b0;
            while (!s_en && n < 10) begin
                tick();
                n++;
            end
            chk("midrst_saw_ren", s_en, 1);
        end
        do_reset(1, '0);
        strm.dout_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midrst_no_valid", s_valid, 0);
            chk("midrst_no_ren", s_en, 0);
        end
        chk("midrst_r_ptr", s_ptr, 0);
        $display("midreset: dout_valid=%0d r_ptr=%0h", s_valid, s_ptr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
